register: RTL and testbench
===========================

REGISTER -- requirements
Module: register

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width in bits of write and read.
REQ-002 The block SHALL have parameter RESET_VALUE, default 0 (WIDTH bits), giving the value loaded on reset.

Ports:
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port RST_N, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port enabled, input, 1 bit: write-enable strobe.
REQ-006 The block SHALL have port addressed, input, 1 bit: register-select; this register is the decoded target.
REQ-007 The block SHALL have port write, input, WIDTH bits: data to store.
REQ-008 The block SHALL have port read, output, WIDTH bits: current stored value.

Function
REQ-009 The block SHALL hold one WIDTH-bit storage element, q.
REQ-010 The read output SHALL equal q at all times, driven directly from the storage element with no combinational path from write, enabled or addressed.
REQ-011 On a CLK rising edge with RST_N=1, enabled=1 and addressed=1, q SHALL load write.
- New value is visible on read immediately after that edge (latency 1 edge).
REQ-012 On a CLK rising edge with RST_N=1 and either enabled=0 or addressed=0, q SHALL hold its value.
REQ-013 Changes on write, enabled or addressed between edges SHALL have no effect on q or read until the next rising edge.
REQ-014 A write SHALL occur on every qualifying edge.
- With enabled=1 and addressed=1 held for several cycles, q tracks the value of write sampled at each edge.
REQ-015 Data width rules:
- Full WIDTH-bit load.
- No sign handling, truncation, byte masking or arithmetic.
REQ-016 The block SHALL contain no other state.
- No handshake or acknowledge outputs.
- No read-side enable: read is always valid.

Reset
REQ-017 On a CLK rising edge with RST_N=0, q SHALL load RESET_VALUE regardless of enabled, addressed or write.
- Reset has priority over a simultaneous write.
REQ-018 RST_N SHALL be sampled only at CLK rising edges.
- Asserting or deasserting RST_N between edges does not change read until the next edge.
REQ-019 Applying reset in the middle of any write sequence SHALL clear q on that edge.
- Normal write behaviour resumes on the first edge with RST_N=1.
REQ-020 Before the first reset edge, the value of q is undefined.
- The bench SHALL apply reset for at least one edge before checking read.

Verification
REQ-021 The bench SHALL cover these directed scenarios (clock period 4 time units, WIDTH=32, RESET_VALUE=0):
- Reset, then write=0xFFFF1111, addressed=1, enabled=0 for 2 edges -> read stays 0x00000000.
- enabled=1, addressed=1, write=0xFFFF1111 -> read=0xFFFF1111 after the next rising edge; enabled=0, write=0x00000001 -> read stays 0xFFFF1111.
- enabled=1, addressed=1; write changes 0x00000001 then 0x00010001 across edges -> read follows each value one edge later; read does not change mid-cycle.
- enabled=0, write=0xF0010001 -> read holds 0x00010001; then addressed=0, enabled=1 -> read still 0x00010001; then addressed=1 -> read=0xF0010001 at the next edge.
- RST_N=0 together with enabled=1, addressed=1, write=0x12345678 -> read=0x00000000 at that edge; RST_N=1 -> read=0x12345678 at the following edge.
- RST_N pulsed low between edges only -> read unchanged.

Source files
------------

// File: rtl/register.sv
// Single WIDTH-bit storage register with a qualified write strobe.
// The read output comes straight from the flop, so there is no path from the write-side inputs.
module register #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             enabled,
    input  logic             addressed,
    input  logic [WIDTH-1:0] write,
    output logic [WIDTH-1:0] read
);

    logic [WIDTH-1:0] q;

    // Reset takes priority over a write presented on the same edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            q <= RESET_VALUE;
        end else if (enabled && addressed) begin
            q <= write;
        end
    end

    assign read = q;

endmodule

// File: tb/tb_register.sv
// Bench for register: directed scenarios followed by random traffic, checked against a simple
// per-edge reference model. A second narrow instance with a non-zero reset value shares the controls.
module tb_register;

    localparam int         WIDTH  = 32;
    localparam logic [7:0] RV8    = 8'h5A;

    logic             CLK;
    logic             RST_N;
    logic             enabled;
    logic             addressed;
    logic [WIDTH-1:0] write;
    logic [WIDTH-1:0] read;
    logic [7:0]       read8;

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] model_q;
    logic [7:0]       model_q8;

    register #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .enabled   (enabled),
        .addressed (addressed),
        .write     (write),
        .read      (read)
    );

    register #(.WIDTH(8), .RESET_VALUE(RV8)) dut8 (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .enabled   (enabled),
        .addressed (addressed),
        .write     (write[7:0]),
        .read      (read8)
    );

    initial CLK = 1'b0;
    always #2 CLK = ~CLK;

    // Advance one rising edge; the model applies the register's rules to the inputs present at it.
    task automatic tick();
        @(posedge CLK);
        if (!RST_N) begin
            model_q  = '0;
            model_q8 = RV8;
        end else if (enabled && addressed) begin
            model_q  = write;
            model_q8 = write[7:0];
        end
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] exp);
        checks++;
        assert (read === exp) else begin
            errors++;
            $error("FAIL %s: read=%h expected=%h", tag, read, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] exp);
        checks++;
        assert (read8 === exp) else begin
            errors++;
            $error("FAIL %s: read8=%h expected=%h", tag, read8, exp);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        model_q   = 'x;
        model_q8  = 'x;
        RST_N     = 1'b0;
        enabled   = 1'b0;
        addressed = 1'b0;
        write     = '0;
        #1;

        // Reset edge.
        tick();
        check("reset", 32'h0000_0000);
        check8("reset8", RV8);

        // Write data presented but not enabled for two edges.
        RST_N = 1'b1; write = 32'hFFFF_1111; addressed = 1'b1; enabled = 1'b0;
        tick(); check("no_en_1", 32'h0000_0000);
        tick(); check("no_en_2", 32'h0000_0000);
        check8("no_en8", RV8);

        // Enabled write, then hold.
        enabled = 1'b1;
        tick(); check("write_ffff1111", 32'hFFFF_1111);
        check8("write8", 8'h11);
        enabled = 1'b0; write = 32'h0000_0001;
        tick(); check("hold_ffff1111", 32'hFFFF_1111);

        // Back-to-back writes; read must not move between edges.
        enabled = 1'b1; addressed = 1'b1; write = 32'h0000_0001;
        tick(); check("seq_0001", 32'h0000_0001);
        write = 32'h0001_0001;
        #1; check("mid_cycle", 32'h0000_0001);
        tick(); check("seq_00010001", 32'h0001_0001);

        // Each qualifier alone blocks the write.
        enabled = 1'b0; write = 32'hF001_0001;
        tick(); check("en0_hold", 32'h0001_0001);
        addressed = 1'b0; enabled = 1'b1;
        tick(); check("ad0_hold", 32'h0001_0001);
        addressed = 1'b1;
        tick(); check("ad1_write", 32'hF001_0001);

        // Reset wins over a simultaneous write; writing resumes after release.
        RST_N = 1'b0; enabled = 1'b1; addressed = 1'b1; write = 32'h1234_5678;
        tick(); check("rst_priority", 32'h0000_0000);
        check8("rst_priority8", RV8);
        RST_N = 1'b1;
        tick(); check("post_rst_write", 32'h1234_5678);
        check8("post_rst_write8", 8'h78);

        // Reset pulsed low only between edges.
        enabled = 1'b0;
        RST_N = 1'b0; #1; RST_N = 1'b1;
        #1; check("rst_glitch_mid", 32'h1234_5678);
        tick(); check("rst_glitch_edge", 32'h1234_5678);

        // Random traffic with occasional reset and mid-cycle input wiggle.
        for (int i = 0; i < 300; i++) begin
            RST_N     = ($urandom_range(0, 15) != 0);
            enabled   = $urandom_range(0, 1);
            addressed = $urandom_range(0, 1);
            write     = $urandom;
            held      = model_q;
            #1;
            if (i % 7 == 0) begin
                write = $urandom;
                check("rand_mid", held);
            end
            tick();
            check("rand", model_q);
            check8("rand8", model_q8);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
